picture_transfer_ctrl: RTL and testbench

Sits between the `uart` block and the single-port picture memory. Decodes one-byte commands from the PC, then either packs received bytes into 32-bit words and writes them to memory (load), or reads memory words and streams their bytes back through the UART transmitter (send). It is the only client of both UART stream interfaces and of the memory port during a transfer.

---
 rtl/picture_ctrl_pkg.sv | 30 +++
 rtl/picture_transfer_ctrl.sv | 171 +++++++++++++++++
 tb/tb_picture_transfer_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/picture_ctrl_pkg.sv
// Shared command codes, state encoding and byte-lane helpers for picture_transfer_ctrl.
package picture_ctrl_pkg;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_SEND = 8'h53;
    localparam int unsigned BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSendRd,
        StSendWait,
        StSendByte,
        StFinish
    } state_t;

    // Little-endian lanes: lane k occupies bits [8k+7:8k].
    function automatic logic [7:0] get_lane(input logic [31:0] word, input logic [1:0] idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] set_lane(input logic [31:0] word, input logic [1:0] idx,
                                             input logic [7:0] value);
        logic [31:0] res;
        res = word;
        res[{idx, 3'b000} +: 8] = value;
        return res;
    endfunction

endpackage

// File: rtl/picture_transfer_ctrl.sv
// UART command decoder that loads picture words into memory or streams them back out.
module picture_transfer_ctrl
    import picture_ctrl_pkg::*;
#(
    parameter int unsigned P_ADDR_WIDTH = 16,
    parameter int unsigned P_WORDS      = 25344
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              rx_data,
    input  logic                    rx_stb,
    output logic [7:0]              tx_data,
    output logic                    tx_stb,
    input  logic                    tx_ack,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [P_ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]             mem_wdata,
    input  logic [31:0]             mem_rdata,
    output logic                    busy,
    output logic                    done
);

    localparam logic [P_ADDR_WIDTH-1:0] LAST_ADDR = P_ADDR_WIDTH'(P_WORDS - 1);
    localparam logic [1:0]              LAST_LANE = 2'(BYTES_PER_WORD - 1);

    state_t                  state_q, state_d;
    logic [P_ADDR_WIDTH-1:0] word_addr_q, word_addr_d;
    logic [1:0]              byte_idx_q, byte_idx_d;
    logic [31:0]             word_q, word_d;
    logic [7:0]              tx_data_q, tx_data_d;
    logic                    tx_stb_q, tx_stb_d;
    logic                    mem_en_q, mem_en_d;
    logic                    mem_we_q, mem_we_d;
    logic [P_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]             mem_wdata_q, mem_wdata_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    last_write;

    // The final write of a load ends the transfer; a byte arriving alongside it is dropped.
    assign last_write = mem_en_q && (word_addr_q == LAST_ADDR);

    always_comb begin
        state_d     = state_q;
        word_addr_d = word_addr_q;
        byte_idx_d  = byte_idx_q;
        word_d      = word_q;
        tx_data_d   = tx_data_q;
        tx_stb_d    = tx_stb_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        done_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (rx_stb && rx_data == CMD_LOAD) begin
                    state_d     = StLoad;
                    word_addr_d = '0;
                    byte_idx_d  = '0;
                end else if (rx_stb && rx_data == CMD_SEND) begin
                    state_d     = StSendRd;
                    word_addr_d = '0;
                    byte_idx_d  = '0;
                    mem_en_d    = 1'b1;
                    mem_addr_d  = '0;
                end
            end
            StLoad: begin
                if (mem_en_q) begin
                    if (last_write) begin
                        state_d = StFinish;
                        done_d  = 1'b1;
                    end else begin
                        word_addr_d = word_addr_q + P_ADDR_WIDTH'(1);
                    end
                end
                if (rx_stb && !last_write) begin
                    word_d     = set_lane(word_q, byte_idx_q, rx_data);
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == LAST_LANE) begin
                        mem_en_d    = 1'b1;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = word_addr_d;
                        mem_wdata_d = word_d;
                    end
                end
            end
            StSendRd: begin
                state_d = StSendWait;
            end
            StSendWait: begin
                word_d    = mem_rdata;
                tx_stb_d  = 1'b1;
                tx_data_d = get_lane(mem_rdata, byte_idx_q);
                state_d   = StSendByte;
            end
            StSendByte: begin
                if (!tx_stb_q) begin
                    // One idle cycle after each ack so the uart sees the request drop.
                    tx_stb_d  = 1'b1;
                    tx_data_d = get_lane(word_q, byte_idx_q);
                end else if (tx_ack) begin
                    tx_stb_d   = 1'b0;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == LAST_LANE) begin
                        if (word_addr_q == LAST_ADDR) begin
                            state_d = StFinish;
                            done_d  = 1'b1;
                        end else begin
                            state_d     = StSendRd;
                            word_addr_d = word_addr_q + P_ADDR_WIDTH'(1);
                            mem_en_d    = 1'b1;
                            mem_addr_d  = word_addr_q + P_ADDR_WIDTH'(1);
                        end
                    end
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            word_addr_q <= '0;
            byte_idx_q  <= '0;
            word_q      <= '0;
            tx_data_q   <= '0;
            tx_stb_q    <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_addr_q <= word_addr_d;
            byte_idx_q  <= byte_idx_d;
            word_q      <= word_d;
            tx_data_q   <= tx_data_d;
            tx_stb_q    <= tx_stb_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_stb    = tx_stb_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_picture_transfer_ctrl.sv
// Bench for picture_transfer_ctrl: memory/uart models plus a word-level reference memory.
module tb_picture_transfer_ctrl;
    import picture_ctrl_pkg::*;

    localparam int unsigned AW = 16;
    localparam int unsigned NW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    rx_data;
    logic          rx_stb;
    logic [7:0]    tx_data;
    logic          tx_stb;
    logic          tx_ack;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          busy;
    logic          done;

    picture_transfer_ctrl #(
        .P_ADDR_WIDTH(AW),
        .P_WORDS     (NW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_stb   (rx_stb),
        .tx_data  (tx_data),
        .tx_stb   (tx_stb),
        .tx_ack   (tx_ack),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int en_cnt = 0;
    int wr_cnt = 0;
    int done_cnt = 0;

    logic [31:0] tb_mem  [NW];
    logic [31:0] ref_mem [NW];
    logic [7:0]  ld_bytes [8];
    logic        pre_we = 1'b0;
    logic        pre_addr = 1'b0;
    logic [31:0] pre_data = '0;

    // Single-port memory with one-cycle read latency.
    always @(posedge clk) begin
        if (pre_we) tb_mem[pre_addr] <= pre_data;
        if (mem_en && mem_addr < AW'(NW)) begin
            if (mem_we) tb_mem[mem_addr[0]] <= mem_wdata;
            else        mem_rdata <= tb_mem[mem_addr[0]];
        end
    end

    always @(negedge clk) begin
        if (mem_en) begin
            en_cnt++;
            checks++;
            if (mem_addr >= AW'(NW)) begin
                errors++;
                $display("FAIL mem_addr_range: got %0d, required < %0d", mem_addr, NW);
            end
        end
        if (mem_en && mem_we) wr_cnt++;
        if (done) done_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_data = b;
        rx_stb  = 1'b1;
        tick();
        rx_stb  = 1'b0;
    endtask

    task automatic preset(input logic idx, input logic [31:0] val);
        pre_addr = idx;
        pre_data = val;
        pre_we   = 1'b1;
        tick();
        pre_we   = 1'b0;
        ref_mem[idx] = val;
    endtask

    task automatic randomize_load();
        for (int i = 0; i < 8; i++) ld_bytes[i] = 8'($urandom);
    endtask

    // Full load of NW words from ld_bytes, checking every write and the done pulse.
    task automatic run_load();
        int          w0;
        int          d0;
        logic [31:0] exp;
        w0 = wr_cnt;
        d0 = done_cnt;
        send_rx(CMD_LOAD);
        checks++;
        if (busy !== 1'b1 || mem_en !== 1'b0) begin
            errors++;
            $display("FAIL load_start: busy=%b mem_en=%b, required busy=1 mem_en=0", busy, mem_en);
        end
        for (int w = 0; w < NW; w++) begin
            exp = 32'h0;
            for (int k = 0; k < 4; k++) exp = exp | (32'(ld_bytes[4*w+k]) << (8 * k));
            ref_mem[w] = exp;
            for (int k = 0; k < 4; k++) begin
                repeat ($urandom_range(2, 0)) tick();
                send_rx(ld_bytes[4*w+k]);
                checks++;
                if (k == 3) begin
                    if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== AW'(w) ||
                        mem_wdata !== exp) begin
                        errors++;
                        $display("FAIL load_write: en=%b we=%b addr=%0d data=%h, required 1 1 %0d %h",
                                 mem_en, mem_we, mem_addr, mem_wdata, w, exp);
                    end
                end else if (mem_en !== 1'b0) begin
                    errors++;
                    $display("FAIL load_early_write: mem_en=%b after byte %0d, required 0", mem_en, k);
                end
            end
        end
        tick();
        checks++;
        if (done !== 1'b1 || busy !== 1'b1 || mem_en !== 1'b0) begin
            errors++;
            $display("FAIL load_done: done=%b busy=%b mem_en=%b, required 1 1 0", done, busy, mem_en);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL load_idle: done=%b busy=%b, required 0 0", done, busy);
        end
        checks++;
        if (wr_cnt - w0 != NW || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL load_counts: writes=%0d dones=%0d, required %0d 1",
                     wr_cnt - w0, done_cnt - d0, NW);
        end
    endtask

    // Full send of ref_mem, acking each byte dmin..dmax clks after tx_stb rises.
    task automatic run_send(input int dmin, input int dmax);
        logic [7:0] exp_b;
        int         d0;
        int         bad;
        int         dly;
        logic       last;
        d0 = done_cnt;
        send_rx(CMD_SEND);
        for (int w = 0; w < NW; w++) begin
            checks++;
            if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== AW'(w) || tx_stb !== 1'b0) begin
                errors++;
                $display("FAIL send_read: en=%b we=%b addr=%0d stb=%b, required 1 0 %0d 0",
                         mem_en, mem_we, mem_addr, tx_stb, w);
            end
            tick();
            checks++;
            if (tx_stb !== 1'b0 || mem_en !== 1'b0) begin
                errors++;
                $display("FAIL send_wait: stb=%b en=%b, required 0 0", tx_stb, mem_en);
            end
            tick();
            for (int k = 0; k < 4; k++) begin
                exp_b = 8'((ref_mem[w] >> (8 * k)) & 32'hFF);
                checks++;
                if (tx_stb !== 1'b1 || tx_data !== exp_b) begin
                    errors++;
                    $display("FAIL send_byte: stb=%b data=%h, required 1 %h (word %0d byte %0d)",
                             tx_stb, tx_data, exp_b, w, k);
                end
                bad = 0;
                dly = $urandom_range(dmax, dmin);
                for (int i = 0; i < dly; i++) begin
                    if (i == 0 && $urandom_range(1, 0) == 1) begin
                        rx_data = ($urandom_range(1, 0) == 1) ? CMD_LOAD : CMD_SEND;
                        rx_stb  = 1'b1;
                    end
                    tick();
                    rx_stb = 1'b0;
                    if (tx_stb !== 1'b1 || tx_data !== exp_b || mem_en !== 1'b0) bad++;
                end
                checks++;
                if (bad != 0) begin
                    errors++;
                    $display("FAIL send_hold: %0d unstable cycles, required 0", bad);
                end
                tx_ack = 1'b1;
                tick();
                tx_ack = 1'b0;
                last = (w == NW - 1) && (k == 3);
                checks++;
                if (tx_stb !== 1'b0 || done !== last) begin
                    errors++;
                    $display("FAIL send_ack: stb=%b done=%b, required 0 %b", tx_stb, done, last);
                end
                if (k < 3) tick();
            end
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL send_end: done=%b busy=%b dones=%0d, required 0 0 1",
                     done, busy, done_cnt - d0);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if ({tx_stb, tx_data, mem_en, mem_we, mem_addr, mem_wdata, busy, done} !== '0) begin
            errors++;
            $display("FAIL %s: stb=%b data=%h en=%b we=%b addr=%h wdata=%h busy=%b done=%b, required all 0",
                     name, tx_stb, tx_data, mem_en, mem_we, mem_addr, mem_wdata, busy, done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset_values");
        rst = 1'b1;
        tick();
    endtask

    task automatic test_load();
        logic [7:0] pat [8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        for (int i = 0; i < 8; i++) ld_bytes[i] = pat[i];
        run_load();
        checks++;
        if (tb_mem[0] !== 32'h04030201 || tb_mem[1] !== 32'hDDCCBBAA) begin
            errors++;
            $display("FAIL load_contents: %h %h, required 04030201 ddccbbaa", tb_mem[0], tb_mem[1]);
        end
    endtask

    task automatic test_send();
        preset(1'b0, 32'h11223344);
        preset(1'b1, 32'h55667788);
        run_send(20, 20);
    endtask

    task automatic test_idle_garbage();
        logic [7:0] g [3] = '{8'h00, 8'hFF, 8'h4D};
        int         e0;
        int         bad;
        e0  = en_cnt;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            send_rx(g[i]);
            if (busy !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad != 0 || en_cnt != e0) begin
            errors++;
            $display("FAIL idle_garbage: busy cycles=%0d mem_en cycles=%0d, required 0 0",
                     bad, en_cnt - e0);
        end
        randomize_load();
        run_load();
    endtask

    task automatic test_cmd_data();
        randomize_load();
        ld_bytes[0] = 8'h4C;
        ld_bytes[1] = 8'h53;
        ld_bytes[2] = 8'h4C;
        ld_bytes[3] = 8'h53;
        run_load();
        checks++;
        if (tb_mem[0] !== 32'h534C534C) begin
            errors++;
            $display("FAIL cmd_data: word0=%h, required 534c534c", tb_mem[0]);
        end
    endtask

    task automatic test_reset_mid_load();
        int w0;
        w0 = wr_cnt;
        send_rx(CMD_LOAD);
        send_rx(8'h01);
        send_rx(8'h02);
        rst = 1'b0;
        tick();
        check_reset_outputs("reset_mid_load");
        rst = 1'b1;
        tick();
        checks++;
        if (wr_cnt != w0) begin
            errors++;
            $display("FAIL reset_mid_load_write: writes=%0d, required 0", wr_cnt - w0);
        end
        randomize_load();
        run_load();
    endtask

    task automatic test_reset_mid_send();
        int d0;
        d0 = done_cnt;
        send_rx(CMD_SEND);
        tick();
        tick();
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_reset_outputs("reset_mid_send");
        rst = 1'b1;
        tick();
        checks++;
        if (done_cnt != d0) begin
            errors++;
            $display("FAIL reset_mid_send_done: dones=%0d, required 0", done_cnt - d0);
        end
        preset(1'b0, $urandom);
        preset(1'b1, $urandom);
        run_send(1, 4);
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            randomize_load();
            run_load();
            repeat ($urandom_range(3, 0)) tick();
            run_send(1, 6);
        end
    endtask

    initial begin
        rst     = 1'b0;
        rx_data = 8'h00;
        rx_stb  = 1'b0;
        tx_ack  = 1'b0;
        test_reset();
        test_load();
        test_send();
        test_idle_garbage();
        test_cmd_data();
        test_reset_mid_load();
        test_reset_mid_send();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
